store_buffer: RTL

//  Posted-write buffer between the pipeline's Memory stage (MemWriteM/ALUOutM/WriteDataM/ReadDataM)
//  and a multi-cycle data memory with req/ack handshake. Stores retire from the core in one cycle
//  and drain in order in the background. Loads bypass queued stores unless their addresses match.

---
 rtl/store_buffer_pkg.sv | 13 +
 rtl/store_buffer_if.sv | 15 +
 rtl/store_buffer_fifo.sv | 85 ++++++++
 rtl/store_buffer.sv | 138 +++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// Shared store-buffer types: drain/read FSM states, buffered entry layout, word-address LSB.
package arm_mem_pkg;
  localparam int ADR_LSB = 2;
  localparam int SB_AW   = 32;
  localparam int SB_DW   = 32;

  typedef enum logic [1:0] {IDLE, WR, RD} sb_state_t;

  typedef struct packed {
    logic [SB_AW-1:0] adr;
    logic [SB_DW-1:0] data;
  } sb_entry_t;
endpackage

// File: rtl/store_buffer_if.sv
// Data-memory side of the store buffer: registered req/we/adr/wdata, one-cycle ack strobe.
interface store_buffer_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  modport master (output mem_req, mem_we, mem_adr, mem_wdata, input  mem_rdata, mem_ack);
  modport slave  (input  mem_req, mem_we, mem_adr, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/store_buffer_fifo.sv
// Circular entry store with head/tail/count and a youngest-match CAM over occupied slots.
// STORE_BUFFER_FWD_EN adds the hit_data forwarding read port.
module store_buffer_fifo
  import arm_mem_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int AW    = 32,
  parameter  int DW    = 32,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic [AW-1:0]       push_adr,
  input  logic [DW-1:0]       push_data,
  input  logic                pop,
  input  logic [AW-1:ADR_LSB] match_wadr,
  output logic [CW-1:0]       count,
  output logic                full,
  output logic [AW-1:0]       head_adr,
  output logic [DW-1:0]       head_data,
  output logic [AW-1:0]       next_adr,
  output logic [DW-1:0]       next_data,
  output logic                any_match
`ifdef STORE_BUFFER_FWD_EN
  ,output logic [DW-1:0]      hit_data
`endif
);
  // entry layout follows the instance widths rather than the package defaults
  typedef struct packed {
    logic [AW-1:0] adr;
    logic [DW-1:0] data;
  } entry_t;

  entry_t        ram [DEPTH];
  logic [PW-1:0] head, tail, head_nxt, idx;
`ifdef STORE_BUFFER_FWD_EN
  logic [PW-1:0] hit_idx;
`endif

  always_ff @(posedge clk)
    if (push) ram[tail] <= '{adr: push_adr, data: push_data};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign full      = (count == CW'(DEPTH));
  assign head_nxt  = head + PW'(1);
  assign head_adr  = ram[head].adr;
  assign head_data = ram[head].data;
  assign next_adr  = ram[head_nxt].adr;
  assign next_data = ram[head_nxt].data;

  // scan oldest to youngest so the last match found is the youngest
  always_comb begin
    any_match = 1'b0;
    idx       = head;
`ifdef STORE_BUFFER_FWD_EN
    hit_idx   = head;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (CW'(k) < count && ram[idx].adr[AW-1:ADR_LSB] == match_wadr) begin
        any_match = 1'b1;
`ifdef STORE_BUFFER_FWD_EN
        hit_idx   = idx;
`endif
      end
    end
  end

`ifdef STORE_BUFFER_FWD_EN
  assign hit_data = ram[hit_idx].data;
`endif
endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer between the Memory stage and a multi-cycle req/ack data memory.
// STORE_BUFFER_FWD_EN: load hits forward from the buffer; otherwise they wait for drain.
module store_buffer
  import arm_mem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   st_valid,
  input  logic                   ld_valid,
  input  logic [AW-1:0]          adr,
  input  logic [DW-1:0]          wdata,
  output logic [DW-1:0]          rdata,
  output logic                   stall,
  output logic [$clog2(DEPTH):0] count,
  store_buffer_if.master         mem
);
  localparam int CW = $clog2(DEPTH) + 1;

  sb_state_t     state_q, state_d;
  logic          req_q, req_d, we_q, we_d;
  logic [AW-1:0] madr_q, madr_d;
  logic [DW-1:0] mwdata_q, mwdata_d;
  logic          full, any_match, push, pop, ld_miss, ld_done;
  logic [AW-1:0] head_adr, next_adr;
  logic [DW-1:0] head_data, next_data;
`ifdef STORE_BUFFER_FWD_EN
  logic [DW-1:0] hit_data;
`endif

  store_buffer_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_adr   (adr),
    .push_data  (wdata),
    .pop        (pop),
    .match_wadr (adr[AW-1:ADR_LSB]),
    .count      (count),
    .full       (full),
    .head_adr   (head_adr),
    .head_data  (head_data),
    .next_adr   (next_adr),
    .next_data  (next_data),
    .any_match  (any_match)
`ifdef STORE_BUFFER_FWD_EN
    ,.hit_data  (hit_data)
`endif
  );

  // a full buffer stalls even when the head retires this cycle
  assign push    = st_valid && !full;
  assign pop     = (state_q == WR) && mem.mem_ack;
  assign ld_done = (state_q == RD) && mem.mem_ack;
  assign ld_miss = ld_valid && !any_match;

`ifdef STORE_BUFFER_FWD_EN
  assign stall = (st_valid && full) || (ld_miss && !ld_done);
  assign rdata = ld_done ? mem.mem_rdata : (ld_valid && any_match) ? hit_data : '0;
`else
  // a matching load waits until its entries drain, then goes to memory as a miss
  assign stall = (st_valid && full) || (ld_valid && !ld_done);
  assign rdata = ld_done ? mem.mem_rdata : '0;
`endif

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    we_d     = we_q;
    madr_d   = madr_q;
    mwdata_d = mwdata_q;
    unique case (state_q)
      IDLE: begin
        if (ld_miss) begin
          state_d = RD;
          req_d   = 1'b1;
          we_d    = 1'b0;
          madr_d  = adr;
        end else if (count != '0) begin
          state_d  = WR;
          req_d    = 1'b1;
          we_d     = 1'b1;
          madr_d   = head_adr;
          mwdata_d = head_data;
        end
      end
      WR: begin
        if (mem.mem_ack) begin
          if (!ld_miss && count > CW'(1)) begin
            madr_d   = next_adr;
            mwdata_d = next_data;
          end else begin
            state_d = IDLE;
            req_d   = 1'b0;
            we_d    = 1'b0;
          end
        end
      end
      RD: begin
        if (mem.mem_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
        we_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      madr_q   <= '0;
      mwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      we_q     <= we_d;
      madr_q   <= madr_d;
      mwdata_q <= mwdata_d;
    end
  end

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_adr   = madr_q;
  assign mem.mem_wdata = mwdata_q;

  st_ld_exclusive: assert property (@(posedge clk) disable iff (!reset) !(st_valid && ld_valid));
endmodule
